// File: rtl/mdu_scheduler_if.sv
// Handshake/data bundle between the E/D pipeline stages and the multiply/divide scheduler.
interface mdu_scheduler_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        mdRequestD;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, operandA, operandB, mdRequestD,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, operandA, operandB, mdRequestD,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/mdu_scheduler.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; counts a fixed latency per op,
// then commits the result and raises a stall while a D-stage MD instruction must wait.
module mdu_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  mdu_scheduler_if.slave md
);

  localparam int unsigned MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [1:0]      r_op;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [1:0]      w_op_nxt;
  logic [31:0]     w_a_nxt;
  logic [31:0]     w_b_nxt;
  logic [31:0]     w_hi_nxt;
  logic [31:0]     w_lo_nxt;

  logic [63:0]     w_prod_s;
  logic [63:0]     w_prod_u;
  logic [31:0]     w_quot_s;
  logic [31:0]     w_rem_s;
  logic [31:0]     w_quot_u;
  logic [31:0]     w_rem_u;
  logic            w_md_start;

  // Operands are explicitly extended so the full 64-bit product is formed.
  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
  assign w_quot_s = $signed(r_a) / $signed(r_b);
  assign w_rem_s  = $signed(r_a) % $signed(r_b);
  assign w_quot_u = r_a / r_b;
  assign w_rem_u  = r_a % r_b;

  assign w_md_start = md.start && (md.op <= 3'd3);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;

    case (r_state)
      IDLE: begin
        if (md.start) begin
          case (md.op)
            3'd0, 3'd1: begin
              w_state_nxt = BUSY;
              w_count_nxt = CW'(MULT_CYCLES);
              w_op_nxt    = md.op[1:0];
              w_a_nxt     = md.operandA;
              w_b_nxt     = md.operandB;
            end
            3'd2, 3'd3: begin
              w_state_nxt = BUSY;
              w_count_nxt = CW'(DIV_CYCLES);
              w_op_nxt    = md.op[1:0];
              w_a_nxt     = md.operandA;
              w_b_nxt     = md.operandB;
            end
            3'd4:    w_hi_nxt = md.operandA;
            3'd5:    w_lo_nxt = md.operandA;
            default: ;
          endcase
        end
      end

      BUSY: begin
        if (r_count == CW'(1)) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
          // A zero divisor burns the full latency but leaves HI/LO untouched.
          case (r_op)
            2'd0: {w_hi_nxt, w_lo_nxt} = w_prod_s;
            2'd1: {w_hi_nxt, w_lo_nxt} = w_prod_u;
            2'd2: if (r_b != '0) begin
                    w_hi_nxt = w_rem_s;
                    w_lo_nxt = w_quot_s;
                  end
            2'd3: if (r_b != '0) begin
                    w_hi_nxt = w_rem_u;
                    w_lo_nxt = w_quot_u;
                  end
            default: ;
          endcase
        end else begin
          w_count_nxt = r_count - CW'(1);
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  assign md.busy  = (r_state == BUSY);
  assign md.stall = md.mdRequestD && (md.busy || w_md_start);
  assign md.hi    = r_hi;
  assign md.lo    = r_lo;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed vector bench for mdu_scheduler: table of ops with expected HI/LO and latency,
// plus hand sequences for stall/ignored-start and mid-op reset.
module tb_mdu_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mdu_scheduler_if bus ();

  mdu_scheduler #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int unsigned lat;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    vecs[3]  = '{3'd0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[4]  = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[5]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
    vecs[8]  = '{3'd2, 32'd5,        32'd0,        32'h00000001, 32'h7FFFFFFC, 10};
    vecs[9]  = '{3'd3, 32'd5,        32'd0,        32'h00000001, 32'h7FFFFFFC, 10};
    vecs[10] = '{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h7FFFFFFC, 0};
    vecs[11] = '{3'd5, 32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 0};
    vecs[12] = '{3'd6, 32'h11111111, 32'd3,        32'h12345678, 32'hCAFEBABE, 0};
    vecs[13] = '{3'd7, 32'h22222222, 32'd3,        32'h12345678, 32'hCAFEBABE, 0};

    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.op         = 3'd6;
    bus.operandA   = '0;
    bus.operandB   = '0;
    bus.mdRequestD = 1'b0;

    repeat (2) tick();
    check("reset_hi",    bus.hi, 32'h0);
    check("reset_lo",    bus.lo, 32'h0);
    check("reset_busy",  {31'd0, bus.busy},  32'd0);
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    reset = 1'b1;
    tick();

    prev_hi = 32'h0;
    prev_lo = 32'h0;
    for (int i = 0; i < 14; i++) begin
      bus.op       = vecs[i].op;
      bus.operandA = vecs[i].a;
      bus.operandB = vecs[i].b;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      bus.op       = 3'd6;
      bus.operandA = 32'hDEADBEEF;
      bus.operandB = 32'h0BADF00D;
      for (int unsigned k = 0; k < vecs[i].lat; k++) begin
        check($sformatf("v%0d_busy_c%0d", i, k), {31'd0, bus.busy}, 32'd1);
        if (k == vecs[i].lat - 1) begin
          check($sformatf("v%0d_hi_hold", i), bus.hi, prev_hi);
          check($sformatf("v%0d_lo_hold", i), bus.lo, prev_lo);
        end
        tick();
      end
      check($sformatf("v%0d_busy_done", i), {31'd0, bus.busy}, 32'd0);
      check($sformatf("v%0d_hi", i), bus.hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), bus.lo, vecs[i].exp_lo);
      prev_hi = vecs[i].exp_hi;
      prev_lo = vecs[i].exp_lo;
    end

    // Stall generation and starts ignored while busy.
    bus.mdRequestD = 1'b1;
    bus.op         = 3'd4;
    bus.operandA   = 32'h1;
    bus.start      = 1'b1;
    #1;
    check("stall_mthi_idle", {31'd0, bus.stall}, 32'd0);
    bus.op       = 3'd0;
    bus.operandA = 32'd3;
    bus.operandB = 32'd4;
    #1;
    check("stall_start_comb", {31'd0, bus.stall}, 32'd1);
    tick();
    bus.start = 1'b0;
    bus.op    = 3'd6;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_busy_c%0d", k), {31'd0, bus.stall}, 32'd1);
      check($sformatf("busy_c%0d", k), {31'd0, bus.busy}, 32'd1);
      case (k)
        1: begin
          bus.start = 1'b1; bus.op = 3'd0;
          bus.operandA = 32'd2; bus.operandB = 32'd3;
        end
        2: begin
          bus.op = 3'd4; bus.operandA = 32'h0000FFFF;
        end
        3: begin
          bus.start = 1'b0; bus.op = 3'd6;
        end
        default: ;
      endcase
      tick();
    end
    check("stall_after",   {31'd0, bus.stall}, 32'd0);
    check("ign_busy_done", {31'd0, bus.busy},  32'd0);
    check("ign_hi",        bus.hi, 32'h0);
    check("ign_lo",        bus.lo, 32'd12);
    tick();
    check("ign_no_restart", {31'd0, bus.busy}, 32'd0);
    check("ign_hi_later",   bus.hi, 32'h0);
    bus.mdRequestD = 1'b0;

    // Reset in the middle of a divide discards it.
    bus.op = 3'd4; bus.operandA = 32'hAAAA5555; bus.start = 1'b1;
    tick();
    check("mthi_pre_reset", bus.hi, 32'hAAAA5555);
    bus.op = 3'd2; bus.operandA = 32'd100; bus.operandB = 32'd7;
    tick();
    bus.start = 1'b0; bus.op = 3'd6;
    check("rst_div_busy", {31'd0, bus.busy}, 32'd1);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_hi",   bus.hi, 32'h0);
    check("rst_mid_lo",   bus.lo, 32'h0);
    reset = 1'b1;
    repeat (12) tick();
    check("rst_no_late_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_no_late_hi",   bus.hi, 32'h0);
    check("rst_no_late_lo",   bus.lo, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
